hmac_sha256_sequencer: RTL

Top-level controller for HMAC-SHA256. It drives the shared SHA-256 padder/parser and compression core through the two passes HMAC needs:

- **Inner pass:** H((K⊕ipad) ‖ msg).
- **Outer pass:** H((K⊕opad) ‖ inner_digest).

It stores a 64-byte key, streams the message from an upstream byte source, resets the core between passes, and returns the 256-bit MAC.

---
 rtl/hmac_sha256_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hmac_sha256_sequencer.sv
// HMAC-SHA256 two-pass sequencer: feeds (K^ipad || msg) then (K^opad || inner digest) to the shared SHA-256 padder/core.
// Latency: start -> core reset next cycle -> first ipad byte the cycle after; MAC registered one cycle after the outer core_done_hash.
// Backpressure: all sending stalls while core_block_full=1; msg_ready drops with it so the upstream source holds its byte.
module hmac_sha256_sequencer #(
  parameter logic [7:0] IPAD = 8'h36,
  parameter logic [7:0] OPAD = 8'h5C
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_we,
  input  logic [5:0]   key_addr,
  input  logic [7:0]   key_byte,
  input  logic         start,
  input  logic         msg_empty,
  input  logic         msg_valid,
  input  logic [7:0]   msg_byte,
  input  logic         msg_last,
  output logic         msg_ready,
  output logic         core_rst_n,
  output logic         core_byte_rdy,
  output logic         core_byte_stop,
  output logic [7:0]   core_data,
  input  logic         core_block_full,
  input  logic         core_done_hash,
  input  logic [255:0] core_digest,
  output logic [255:0] hmac_out,
  output logic         hmac_valid,
  output logic         busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR1, S_IPAD, S_MSG, S_STOP1, S_CLR2, S_OPAD, S_INNER, S_STOP2
  } state_t;

  state_t       state, state_nxt;
  logic [6:0]   cnt;
  logic         empty_q;
  logic [255:0] inner;
  logic [7:0]   key_ram [64];

  assign busy       = (state != S_IDLE);
  assign core_rst_n = rst & ~((state == S_CLR1) | (state == S_CLR2));

  // Next state plus Mealy byte-send outputs; every byte is offered only while the padder has room
  always_comb begin
    state_nxt      = state;
    core_byte_rdy  = 1'b0;
    core_byte_stop = 1'b0;
    core_data      = 8'h00;
    msg_ready      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_CLR1;
      S_CLR1: state_nxt = S_IPAD;
      S_IPAD: begin
        core_byte_rdy = ~core_block_full;
        core_data     = key_ram[cnt[5:0]] ^ IPAD;
        if (core_byte_rdy && cnt == 7'd63) state_nxt = empty_q ? S_STOP1 : S_MSG;
      end
      S_MSG: begin
        msg_ready     = ~core_block_full;
        core_byte_rdy = msg_valid & ~core_block_full;
        core_data     = msg_byte;
        if (core_byte_rdy && msg_last) state_nxt = S_STOP1;
      end
      S_STOP1: begin
        core_byte_stop = 1'b1;
        if (core_done_hash) state_nxt = S_CLR2;
      end
      S_CLR2: state_nxt = S_OPAD;
      S_OPAD: begin
        core_byte_rdy = ~core_block_full;
        core_data     = key_ram[cnt[5:0]] ^ OPAD;
        if (core_byte_rdy && cnt == 7'd63) state_nxt = S_INNER;
      end
      S_INNER: begin
        // cnt=0 selects inner[255:248]: the digest goes out MSB byte first
        core_byte_rdy = ~core_block_full;
        core_data     = inner[{~cnt[4:0], 3'b000} +: 8];
        if (core_byte_rdy && cnt == 7'd31) state_nxt = S_STOP2;
      end
      S_STOP2: begin
        core_byte_stop = 1'b1;
        if (core_done_hash) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, byte counter (cleared on every state change, saturating at 64), digest captures and done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 7'd0;
      empty_q    <= 1'b0;
      inner      <= '0;
      hmac_out   <= '0;
      hmac_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      hmac_valid <= 1'b0;
      if (state_nxt != state)
        cnt <= 7'd0;
      else if (core_byte_rdy && cnt != 7'd64)
        cnt <= cnt + 7'd1;
      if (state == S_IDLE && start)
        empty_q <= msg_empty;
      if (state == S_STOP1 && core_done_hash)
        inner <= core_digest;
      if (state == S_STOP2 && core_done_hash) begin
        hmac_out   <= core_digest;
        hmac_valid <= 1'b1;
      end
    end
  end

  // Key store: host writes are taken only while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (key_we && state == S_IDLE)
      key_ram[key_addr] <= key_byte;
  end

endmodule
